dmem_sized: RTL



---
 rtl/dmem_defs.sv | 24 ++
 rtl/dmem_bank.sv | 26 ++
 rtl/dmem_sized.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/dmem_defs.sv
// rtl/dmem_defs.sv - shared size/state encodings and access-check helper for dmem_sized
package dmem_defs;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11
    } size_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        DONE = 2'b10
    } state_e;

    localparam int WS_W = 3;

    // Reserved size or an access not aligned to its own size.
    function automatic logic bad_access(input logic [1:0] sz, input logic [1:0] lo);
        return (sz == SZ_RSVD) || (sz == SZ_HALF && lo[0]) || (sz == SZ_WORD && lo != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - byte storage with 4-lane write enable and 4-byte big-endian combinational read
module dmem_bank #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic [ADDR_W-3:0] word_addr,
    input  logic [3:0]        we,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [7:0] mem [2**ADDR_W];

    // Lane 0 is the lowest address and carries the most significant byte.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[3-i]) begin
                mem[{word_addr, 2'(i)}] <= wdata[8*(3-i) +: 8];
            end
        end
    end

    assign rdata = {mem[{word_addr, 2'd0}], mem[{word_addr, 2'd1}],
                    mem[{word_addr, 2'd2}], mem[{word_addr, 2'd3}]};

endmodule

// File: rtl/dmem_sized.sv
// rtl/dmem_sized.sv - sized big-endian data memory with alignment checks and wait-state handshake
import dmem_defs::*;

module dmem_sized #(
    parameter int ADDR_W      = 12,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dm_cs,
    input  logic        dm_rd,
    input  logic        dm_wr,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] Address,
    input  logic [31:0] D_in,
    output logic [31:0] D_Out,
    output logic        dm_ready,
    output logic        dm_busy,
    output logic        dm_err
);

    localparam logic [WS_W-1:0] WS_INIT = WS_W'(WAIT_STATES);

    state_e            state, state_nxt;
    logic [WS_W-1:0]   cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       din_q;
    logic [1:0]        size_q;
    logic              sext_q, wr_q, err_q;

    logic              accept, req_err, commit;
    logic [ADDR_W-1:0] cur_addr;
    logic [31:0]       cur_din;
    logic [1:0]        cur_size;
    logic              cur_sext, cur_wr;
    logic [1:0]        lane;
    logic [3:0]        lane_we, bank_we;
    logic [31:0]       lane_wdata, rdata, rd_val;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    logic              unused_addr;

    assign unused_addr = ^Address[31:ADDR_W];

    assign accept  = (state == IDLE) && dm_cs && (dm_rd || dm_wr);
    assign req_err = (dm_rd && dm_wr) || bad_access(size, Address[1:0]);

    // With no wait states the access happens on the accept edge, so it uses the live request.
    always_comb begin
        if (state == IDLE) begin
            cur_addr = Address[ADDR_W-1:0];
            cur_din  = D_in;
            cur_size = size;
            cur_sext = sign_ext;
            cur_wr   = dm_wr;
        end else begin
            cur_addr = addr_q;
            cur_din  = din_q;
            cur_size = size_q;
            cur_sext = sext_q;
            cur_wr   = wr_q;
        end
    end

    always_comb begin
        state_nxt = state;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_nxt = DONE;
                    end else if (WAIT_STATES == 0) begin
                        state_nxt = DONE;
                        commit    = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == WS_W'(1)) begin
                    state_nxt = DONE;
                    commit    = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign lane = cur_addr[1:0];

    always_comb begin
        lane_we    = 4'b1111;
        lane_wdata = cur_din;
        case (cur_size)
            SZ_BYTE: begin
                lane_we    = 4'b1000 >> lane;
                lane_wdata = {4{cur_din[7:0]}};
            end
            SZ_HALF: begin
                lane_we    = lane[1] ? 4'b0011 : 4'b1100;
                lane_wdata = {2{cur_din[15:0]}};
            end
            default: ;
        endcase
    end

    assign bank_we = (commit && cur_wr) ? lane_we : 4'b0000;

    dmem_bank #(.ADDR_W(ADDR_W)) u_bank (
        .clk       (clk),
        .word_addr (cur_addr[ADDR_W-1:2]),
        .we        (bank_we),
        .wdata     (lane_wdata),
        .rdata     (rdata)
    );

    assign rd_byte = 8'(rdata >> {~lane, 3'b000});
    assign rd_half = lane[1] ? rdata[15:0] : rdata[31:16];

    always_comb begin
        case (cur_size)
            SZ_BYTE: rd_val = {{24{cur_sext & rd_byte[7]}}, rd_byte};
            SZ_HALF: rd_val = {{16{cur_sext & rd_half[15]}}, rd_half};
            default: rd_val = rdata;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            D_Out  <= '0;
            addr_q <= '0;
            din_q  <= '0;
            size_q <= '0;
            sext_q <= 1'b0;
            wr_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q <= Address[ADDR_W-1:0];
                din_q  <= D_in;
                size_q <= size;
                sext_q <= sign_ext;
                wr_q   <= dm_wr;
                err_q  <= req_err;
                cnt    <= WS_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - WS_W'(1);
            end
            if (commit && !cur_wr) begin
                D_Out <= rd_val;
            end
        end
    end

    assign dm_ready = (state == DONE);
    assign dm_err   = (state == DONE) && err_q;
    assign dm_busy  = (state != IDLE);

endmodule
